workout_report_tx: RTL and testbench

Consumer of the step-calculator statistics outputs. It snapshots the workout statistics on request or periodically, then serializes them into a framed byte stream over a valid/ready interface for a UART or BLE bridge. It sits between the step calculator and the link layer. It is a single-clock framer with a handshake-driven FSM.

---
 rtl/workout_pkg.sv | 57 +++++
 rtl/workout_frame_mux.sv | 35 +++
 rtl/workout_report_tx.sv | 179 +++++++++++++++++
 tb/tb_workout_report_tx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/workout_pkg.sv
// workout_pkg: shared frame constants, FSM state type, payload offsets and the
// snapshot record used by the workout report framer.
package workout_pkg;

  localparam logic [7:0] FRAME_LEN = 8'd16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LEN  = 3'd2,
    PAY  = 3'd3,
    CSUM = 3'd4
  } state_e;

  // Payload byte offsets; multi-byte fields go out MSB first
  localparam logic [3:0] OFF_STEPS_HI = 4'd0;
  localparam logic [3:0] OFF_STEPS_LO = 4'd1;
  localparam logic [3:0] OFF_DIST_B3  = 4'd2;
  localparam logic [3:0] OFF_DIST_B2  = 4'd3;
  localparam logic [3:0] OFF_DIST_B1  = 4'd4;
  localparam logic [3:0] OFF_DIST_B0  = 4'd5;
  localparam logic [3:0] OFF_CAL_B3   = 4'd6;
  localparam logic [3:0] OFF_CAL_B2   = 4'd7;
  localparam logic [3:0] OFF_CAL_B1   = 4'd8;
  localparam logic [3:0] OFF_CAL_B0   = 4'd9;
  localparam logic [3:0] OFF_AVG_HR   = 4'd10;
  localparam logic [3:0] OFF_MAX_HR   = 4'd11;
  localparam logic [3:0] OFF_TIME     = 4'd12;
  localparam logic [3:0] OFF_CLASS    = 4'd13;
  localparam logic [3:0] OFF_SPEED_HI = 4'd14;
  localparam logic [3:0] OFF_SPEED_LO = 4'd15;

  localparam logic [1:0] HR_SAFE      = 2'b00;
  localparam logic [1:0] HR_WARNING   = 2'b01;
  localparam logic [1:0] HR_EMERGENCY = 2'b10;
  localparam logic [1:0] INT_WARMUP   = 2'b00;
  localparam logic [1:0] INT_FAT_BURN = 2'b01;
  localparam logic [1:0] INT_INTENSE  = 2'b10;

  typedef struct packed {
    logic [15:0] steps;
    logic [31:0] distance;
    logic [31:0] calories;
    logic [7:0]  avg_hr;
    logic [7:0]  max_hr;
    logic [7:0]  time_elapsed;
    logic [1:0]  intensity;
    logic [1:0]  hr_class;
    logic [15:0] speed;
  } snapshot_t;

  function automatic logic [7:0] class_byte(input logic [1:0] intensity,
                                            input logic [1:0] hr_class);
    return {4'b0000, intensity, hr_class};
  endfunction

endpackage

// File: rtl/workout_frame_mux.sv
// workout_frame_mux: selects one payload byte of the captured snapshot by
// payload index.
module workout_frame_mux
  import workout_pkg::*;
(
  input  snapshot_t  i_snap,
  input  logic [3:0] i_idx,
  output logic [7:0] o_byte
);

  // Index-to-field byte selection
  always_comb begin
    o_byte = 8'h00;
    case (i_idx)
      OFF_STEPS_HI: o_byte = i_snap.steps[15:8];
      OFF_STEPS_LO: o_byte = i_snap.steps[7:0];
      OFF_DIST_B3:  o_byte = i_snap.distance[31:24];
      OFF_DIST_B2:  o_byte = i_snap.distance[23:16];
      OFF_DIST_B1:  o_byte = i_snap.distance[15:8];
      OFF_DIST_B0:  o_byte = i_snap.distance[7:0];
      OFF_CAL_B3:   o_byte = i_snap.calories[31:24];
      OFF_CAL_B2:   o_byte = i_snap.calories[23:16];
      OFF_CAL_B1:   o_byte = i_snap.calories[15:8];
      OFF_CAL_B0:   o_byte = i_snap.calories[7:0];
      OFF_AVG_HR:   o_byte = i_snap.avg_hr;
      OFF_MAX_HR:   o_byte = i_snap.max_hr;
      OFF_TIME:     o_byte = i_snap.time_elapsed;
      OFF_CLASS:    o_byte = class_byte(i_snap.intensity, i_snap.hr_class);
      OFF_SPEED_HI: o_byte = i_snap.speed[15:8];
      OFF_SPEED_LO: o_byte = i_snap.speed[7:0];
      default:      o_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/workout_report_tx.sv
// workout_report_tx: snapshots workout statistics on request or every AUTO_SECS
// ticks and streams them as a framed byte sequence. Define WORKOUT_REPORT_CSUM_EN
// to append a two's-complement checksum byte after the payload.
module workout_report_tx
  import workout_pkg::*;
#(
  parameter logic [7:0]  HEADER    = 8'hA5,
  parameter int unsigned AUTO_SECS = 32'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        snap_req,
  input  logic [15:0] total_steps,
  input  logic [31:0] total_distance,
  input  logic [31:0] total_calories,
  input  logic [31:0] average_heart_rate,
  input  logic [7:0]  max_heart_rate,
  input  logic [7:0]  time_elapsed,
  input  logic [1:0]  heart_rate_classification,
  input  logic [1:0]  workout_intensity,
  input  logic [15:0] speed,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        req_dropped
);

  localparam int unsigned CNT_W = (AUTO_SECS > 32'd1) ? $clog2(AUTO_SECS) : 32'd1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (AUTO_SECS == 32'd0) ? '0 : CNT_W'(AUTO_SECS - 32'd1);

  state_e           r_state;
  logic [3:0]       r_idx;
  logic [CNT_W-1:0] r_auto_cnt;
  snapshot_t        r_snap;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;
  logic             r_busy;
  logic             r_frame_done;
  logic             r_req_dropped;
`ifdef WORKOUT_REPORT_CSUM_EN
  logic [7:0]       r_sum;
`endif

  logic       w_auto_trig;
  logic       w_trig;
  logic       w_xfer;
  logic [3:0] w_mux_idx;
  logic [7:0] w_pay_byte;
  logic       w_unused_avg_hr;

  assign w_auto_trig     = (AUTO_SECS != 32'd0) && tick_1hz && (r_auto_cnt == CNT_LAST);
  assign w_trig          = snap_req | w_auto_trig;
  assign w_xfer          = r_tx_valid & tx_ready;
  // The mux looks one byte ahead so the next tx_data can be registered
  assign w_mux_idx       = (r_state == LEN) ? 4'd0 : (r_idx + 4'd1);
  assign w_unused_avg_hr = ^average_heart_rate[31:8];

  workout_frame_mux u_mux (
    .i_snap (r_snap),
    .i_idx  (w_mux_idx),
    .o_byte (w_pay_byte)
  );

  // Free-running auto report counter; keeps counting while a frame is in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_auto_cnt <= '0;
    end else if (tick_1hz && (AUTO_SECS != 32'd0)) begin
      r_auto_cnt <= w_auto_trig ? '0 : (r_auto_cnt + CNT_W'(1'b1));
    end
  end

  // Framer FSM: capture, byte sequencing and handshake outputs.
  // busy covers the frame_done cycle so a trigger there is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_idx         <= 4'd0;
      r_snap        <= '0;
      r_tx_data     <= 8'h00;
      r_tx_valid    <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_req_dropped <= 1'b0;
`ifdef WORKOUT_REPORT_CSUM_EN
      r_sum         <= 8'h00;
`endif
    end else begin
      r_frame_done  <= 1'b0;
      r_req_dropped <= w_trig & r_busy;
      case (r_state)
        IDLE: begin
          if (w_trig && !r_busy) begin
            r_snap <= '{steps:        total_steps,
                        distance:     total_distance,
                        calories:     total_calories,
                        avg_hr:       average_heart_rate[7:0],
                        max_hr:       max_heart_rate,
                        time_elapsed: time_elapsed,
                        intensity:    workout_intensity,
                        hr_class:     heart_rate_classification,
                        speed:        speed};
            r_state    <= HDR;
            r_tx_data  <= HEADER;
            r_tx_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_idx      <= 4'd0;
          end else begin
            r_busy <= 1'b0;
          end
        end
        HDR: begin
          if (w_xfer) begin
            r_state   <= LEN;
            r_tx_data <= FRAME_LEN;
          end
        end
        LEN: begin
          if (w_xfer) begin
            r_state   <= PAY;
            r_idx     <= 4'd0;
            r_tx_data <= w_pay_byte;
`ifdef WORKOUT_REPORT_CSUM_EN
            r_sum     <= r_tx_data;
`endif
          end
        end
        PAY: begin
          if (w_xfer) begin
            if (r_idx == 4'd15) begin
`ifdef WORKOUT_REPORT_CSUM_EN
              r_state   <= CSUM;
              r_tx_data <= 8'h00 - (r_sum + r_tx_data);
`else
              r_state      <= IDLE;
              r_tx_valid   <= 1'b0;
              r_tx_data    <= 8'h00;
              r_frame_done <= 1'b1;
`endif
            end else begin
              r_idx     <= r_idx + 4'd1;
              r_tx_data <= w_pay_byte;
`ifdef WORKOUT_REPORT_CSUM_EN
              r_sum     <= r_sum + r_tx_data;
`endif
            end
          end
        end
        CSUM: begin
`ifdef WORKOUT_REPORT_CSUM_EN
          if (w_xfer) begin
            r_state      <= IDLE;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_frame_done <= 1'b1;
          end
`else
          r_state <= IDLE;
`endif
        end
        default: begin
          r_state    <= IDLE;
          r_tx_valid <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign req_dropped = r_req_dropped;

endmodule

// File: tb/tb_workout_report_tx.sv
// tb_workout_report_tx: directed stimulus with a queue-based frame model checked
// every cycle, plus literal frame/timing expectations. Honours WORKOUT_REPORT_CSUM_EN.
module tb_workout_report_tx;

  localparam int AUTO = 3;
  localparam logic [7:0] HDR_BYTE = 8'hA5;
`ifdef WORKOUT_REPORT_CSUM_EN
  localparam int NB = 19;
`else
  localparam int NB = 18;
`endif

  logic        clk, rst, tick_1hz, snap_req, tx_ready;
  logic [15:0] in_steps, in_speed;
  logic [31:0] in_dist, in_cal, in_avg;
  logic [7:0]  in_max, in_time;
  logic [1:0]  in_class, in_int;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, frame_done, req_dropped;

  workout_report_tx #(.HEADER(8'hA5), .AUTO_SECS(AUTO)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .snap_req(snap_req),
    .total_steps(in_steps), .total_distance(in_dist), .total_calories(in_cal),
    .average_heart_rate(in_avg), .max_heart_rate(in_max), .time_elapsed(in_time),
    .heart_rate_classification(in_class), .workout_intensity(in_int), .speed(in_speed),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .frame_done(frame_done), .req_dropped(req_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame for the test-plan input set
  logic [7:0] lit [19] = '{8'hA5, 8'h10, 8'h01, 8'h02, 8'h00, 8'h00, 8'h03, 8'h04,
                           8'h00, 8'h00, 8'h00, 8'h05, 8'h64, 8'h96, 8'h0A, 8'h04,
                           8'h00, 8'h1E, 8'hBB};
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  // Behavioural model: a queue of bytes still owed plus a few status flags
  logic [7:0] m_q [$];
  bit m_live, m_valid, m_busy, m_done, m_drop;
  int m_auto;

  task automatic build_frame();
    logic [7:0] pay [16];
    logic [7:0] sum;
    pay = '{in_steps[15:8], in_steps[7:0],
            in_dist[31:24], in_dist[23:16], in_dist[15:8], in_dist[7:0],
            in_cal[31:24], in_cal[23:16], in_cal[15:8], in_cal[7:0],
            in_avg[7:0], in_max, in_time, {4'b0000, in_int, in_class},
            in_speed[15:8], in_speed[7:0]};
    m_q.delete();
    m_q.push_back(HDR_BYTE);
    m_q.push_back(8'd16);
    sum = 8'd16;
    for (int i = 0; i < 16; i++) begin
      m_q.push_back(pay[i]);
      sum = sum + pay[i];
    end
`ifdef WORKOUT_REPORT_CSUM_EN
    m_q.push_back(8'd0 - sum);
`endif
  endtask

  task automatic model_step();
    bit trig, auto_t;
    if (!rst) begin
      m_live = 1'b1; m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_drop = 1'b0;
      m_q.delete(); m_auto = 0;
    end else begin
      auto_t = tick_1hz && (m_auto == AUTO - 1);
      if (tick_1hz) m_auto = auto_t ? 0 : m_auto + 1;
      trig   = snap_req || auto_t;
      m_drop = trig && m_busy;
      m_done = 1'b0;
      if (m_busy && !m_valid) begin
        m_busy = 1'b0;
      end else if (m_valid && tx_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_valid = 1'b0;
          m_done  = 1'b1;
        end
      end else if (!m_busy && trig) begin
        build_frame();
        m_valid = 1'b1;
        m_busy  = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison and transfer recording on the falling edge
  logic [7:0] rec [$];
  int done_cnt = 0;
  int drop_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("tx_valid", tx_valid, m_valid);
      chk("busy", busy, m_busy);
      chk("frame_done", frame_done, m_done);
      chk("req_dropped", req_dropped, m_drop);
      if (m_valid) chk("tx_data", tx_data, m_q[0]);
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) rec.push_back(tx_data);
    if (frame_done === 1'b1) done_cnt++;
    if (req_dropped === 1'b1) drop_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_inputs();
    in_steps = 16'h0102; in_dist = 32'h0000_0304; in_cal = 32'd5; in_avg = 32'd100;
    in_max = 8'd150; in_time = 8'd10; in_int = 2'b01; in_class = 2'b00; in_speed = 16'h001E;
  endtask

  // Pulse snap_req from an idle cycle and pin the one-cycle start latency
  task automatic snap_and_check(input string tag);
    rec.delete();
    snap_req = 1'b1;
    chk({tag, "_valid_pre"}, tx_valid, 1'b0);
    step();
    snap_req = 1'b0;
    chk({tag, "_valid_lat1"}, tx_valid, 1'b1);
    chk({tag, "_hdr"}, tx_data, 8'hA5);
  endtask

  task automatic run_frame(input bit toggle, input int budget);
    int start = done_cnt;
    int k = 0;
    while (done_cnt == start && k < budget) begin
      if (toggle) tx_ready = pat[k % 4];
      step();
      k++;
    end
    chk("frame_timeout", (done_cnt != start), 1'b1);
    tx_ready = 1'b1;
  endtask

  task automatic wait_rec(input int n, input int budget);
    int k = 0;
    while (rec.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("wait_rec_timeout", (rec.size() >= n), 1'b1);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_len"}, rec.size(), NB);
    for (int i = 0; i < NB; i++)
      if (i < rec.size()) chk($sformatf("%s_byte%0d", tag, i), rec[i], lit[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, f0;
    rst = 1'b0; tick_1hz = 1'b0; snap_req = 1'b0; tx_ready = 1'b1;
    set_inputs();
    repeat (3) step();
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_drop", req_dropped, 1'b0);
    rst = 1'b1;
    repeat (2) step();

    // 1: basic frame at full rate
    snap_and_check("t1");
    run_frame(1'b0, 60);
    check_frame("t1");
    chk("t1_done_cnt", done_cnt, 1);
    repeat (3) step();

    // 2: tx_ready stalls 1,0,0,1
    snap_and_check("t2");
    run_frame(1'b1, 200);
    check_frame("t2");
    repeat (3) step();

    // 3: inputs change after capture
    snap_and_check("t3");
    in_steps = 16'hFFFF; in_dist = 32'hDEAD_BEEF; in_cal = 32'h1234_5678; in_avg = 32'hFF;
    in_max = 8'h11; in_time = 8'h22; in_int = 2'b10; in_class = 2'b10; in_speed = 16'hABCD;
    run_frame(1'b0, 60);
    check_frame("t3");
    set_inputs();
    repeat (3) step();

    // 4: trigger while busy, in the frame_done cycle, and one cycle later
    d0 = drop_cnt; f0 = done_cnt;
    snap_and_check("t4");
    wait_rec(5, 40);
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    run_frame(1'b0, 60);
    check_frame("t4a");
    chk("t4_drop_mid", drop_cnt - d0, 1);
    chk("t4_one_frame", done_cnt - f0, 1);
    rec.delete();
    snap_req = 1'b1;
    step();
    chk("t4_no_start_in_done", tx_valid, 1'b0);
    step();
    snap_req = 1'b0;
    chk("t4_restart", tx_valid, 1'b1);
    chk("t4_drop_done_cycle", drop_cnt - d0, 2);
    run_frame(1'b0, 60);
    check_frame("t4b");
    repeat (3) step();

    // 5: auto reports every third tick
    f0 = done_cnt;
    for (int t = 1; t <= 3; t++) begin
      tick_1hz = 1'b1;
      if (t == 3) rec.delete();
      step();
      tick_1hz = 1'b0;
      chk($sformatf("t5_auto_tick%0d", t), tx_valid, (t == 3));
      repeat (3) step();
    end
    run_frame(1'b0, 60);
    check_frame("t5a");
    repeat (3) step();
    for (int t = 1; t <= 2; t++) begin
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
      repeat (3) step();
    end
    d0 = drop_cnt;
    tick_1hz = 1'b1;
    snap_and_check("t5b");
    tick_1hz = 1'b0;
    chk("t5_simul_no_drop", drop_cnt - d0, 0);
    for (int t = 1; t <= 3; t++) begin
      repeat (3) step();
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
    end
    run_frame(1'b0, 60);
    check_frame("t5b");
    chk("t5_busy_auto_drop", drop_cnt - d0, 1);
    chk("t5_frames", done_cnt - f0, 2);
    repeat (4) step();
    chk("t5_no_extra", tx_valid, 1'b0);

    // 6: reset mid-frame
    snap_and_check("t6");
    wait_rec(8, 40);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t6_valid_after_rst", tx_valid, 1'b0);
    chk("t6_busy_after_rst", busy, 1'b0);
    step();
    snap_and_check("t6b");
    run_frame(1'b0, 60);
    check_frame("t6b");
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
